ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Serves the core-to-host direction of the data_io ioctl interface. It is the reader counterpart of the ROM download path, used for NVRAM/hiscore/ROM dump uploads.
- Fetches 16-bit words from an SDRAM port over the toggle req/ack handshake and returns them to data_io one byte at a time.
- Holds a 2-entry word buffer (current word plus prefetched next word), so sequential uploads rarely stall.
- Sits between data_io and a spare SDRAM port (port1/port2 style) in the *_MiST top level.

Parameters:
- AW, 23, SDRAM word-address width (mem_a).
- BASE_WORD, 0, word offset added to ioctl_addr[AW:1] to form mem_a (modulo 2^AW).
- PREFETCH, 1, 1 = fetch word+1 after the high byte of a word is served; 0 = demand fetch only.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_upload  in  1  upload session active.
- ioctl_rd  in  1  one-cycle strobe; a byte at ioctl_addr is requested.
- ioctl_addr  in  25  byte address; sampled only when ioctl_rd=1.
- ioctl_din  out  8  requested byte.
- ioctl_din_ready  out  1  high while ioctl_din is valid for the last ioctl_rd.
- busy  out  1  a fetch is outstanding or a drain is in progress.
- mem_req  out  1  toggle request to the SDRAM port.
- mem_ack  in  1  toggle acknowledge; the transfer is complete when mem_ack==mem_req.
- mem_a  out  AW  word address; held stable while the request is outstanding.
- mem_q  in  16  read data; valid in the cycle mem_ack becomes equal to mem_req.

Behaviour:
- Byte order: even byte address returns mem_q[7:0]; odd byte address returns mem_q[15:8]. This matches ds={a0,~a0} on the download path.
- Buffer slots S0 and S1 each hold {valid, word address, data}.
- A hit is a slot that is valid and whose word address equals ioctl_addr[24:1]+BASE_WORD.
- States: DRAIN, IDLE, FETCH, PREFETCH.
- Reset:
  - ioctl_din=0, ioctl_din_ready=0, mem_a=0, busy=1, both slots invalid, pending cleared, state=DRAIN.
  - mem_req is NOT modified by reset. Its power-up value is 0.
- DRAIN:
  - Wait until mem_ack==mem_req, then go to IDLE with busy=0.
  - Any in-flight data is discarded.
  - ioctl_rd during DRAIN is latched as pending.
- IDLE, ioctl_rd hit:
  - On the next cycle, ioctl_din = selected byte and ioctl_din_ready=1. Latency is 1 cycle.
- IDLE, ioctl_rd miss:
  - ioctl_din_ready<=0; set mem_a; toggle mem_req; state=FETCH; busy=1.
- FETCH:
  - On mem_ack==mem_req, write mem_q into the slot not holding the most recently used word.
  - Drive the byte and ioctl_din_ready=1 in the next cycle; state=IDLE.
- Prefetch trigger: PREFETCH=1, the served byte was odd, and the word+1 slot is absent.
  - After serving, issue a fetch of word+1 (wraps modulo 2^AW) into the other slot; state=PREFETCH.
- ioctl_rd during FETCH or PREFETCH:
  - Latch address as pending (one entry; a newer rd overwrites it) and set ioctl_din_ready=0.
  - On completion, evaluate pending as a new request in the same cycle.
  - A completed prefetch that matches the pending address is a hit.
- ioctl_din_ready falls to 0 the cycle after any ioctl_rd is accepted, unless that rd is served with 1-cycle latency. In that case ready stays 1 and ioctl_din updates.
- ioctl_upload rising or falling edge: invalidate both slots and clear pending. An outstanding transfer completes and its data is dropped.
- ioctl_rd with ioctl_upload=0 is ignored.
- At most one SDRAM request is outstanding. mem_req toggles only when mem_ack==mem_req.
- mem_a: bit count AW; the sum with BASE_WORD is truncated.

Test Plan:
- Reset while idle, mem_req=mem_ack=0 -> DRAIN lasts 1 cycle, busy 1->0, ioctl_din=0, ready=0, no mem_req toggle.
- Upload, rd addr 0x000000 (mem_q=0xBEEF, ack after 5 cycles) -> one mem_req toggle with mem_a=0; ioctl_din=0xEF, ready=1 one cycle after ack. rd addr 0x000001 -> ioctl_din=0xBE, latency 1, no new fetch.
- PREFETCH=1 continuing from the previous scenario -> after serving 0x000001, mem_req toggles with mem_a=1. rd 0x000002 issued mid-prefetch -> pending, served from prefetched data with no extra request.
- BASE_WORD=0x100000, rd addr 0x1FFFFFE, AW=23 -> mem_a=(0xFFFFFF+0x100000) mod 2^23=0x0FFFFF.
- Reset asserted 2 cycles after a mem_req toggle, ack arrives 6 cycles later -> busy stays 1 until ack, mem_req unchanged, returned data not presented, slots invalid.
- ioctl_upload dropped and raised again, then rd addr 0x000000 -> miss, new fetch issued even though the word was previously cached.

Source files
------------

// File: rtl/ioctl_upload_reader.sv
// Core-to-host upload reader: serves ioctl_rd bytes from a two-word cache that
// is filled over a toggle req/ack SDRAM port, with optional sequential prefetch.
module ioctl_upload_reader #(
  parameter int AW        = 23,
  parameter int BASE_WORD = 0,
  parameter int PREFETCH  = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_din_ready,
  output logic          busy,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_a,
  input  logic [15:0]   mem_q
);

  typedef enum logic [1:0] {ST_DRAIN, ST_IDLE, ST_FETCH, ST_PREFETCH} state_t;

  localparam logic [31:0] BASE = BASE_WORD;

  function automatic logic [AW-1:0] word_of(input logic [24:0] addr);
    logic [31:0] sum;
    sum = {8'd0, addr[24:1]} + BASE;
    return sum[AW-1:0];
  endfunction

  state_t        state, state_n;
  logic [1:0]    slot_vld, slot_vld_n, eff_vld;
  logic [AW-1:0] slot_adr [2];
  logic [AW-1:0] slot_adr_n [2];
  logic [AW-1:0] eff_adr [2];
  logic [15:0]   slot_dat [2];
  logic [15:0]   slot_dat_n [2];
  logic [15:0]   eff_dat [2];
  logic          mru, mru_n, fetch_slot, fetch_slot_n, drop, drop_n, upload_q;
  logic          pend_vld, pend_vld_n;
  logic [24:0]   pend_addr, pend_addr_n, dem_addr, dem_addr_n;
  // mem_req is deliberately outside reset; it powers up low.
  logic          req_tgl = 1'b0;
  logic          req_n;
  logic [AW-1:0] mem_a_n;
  logic [7:0]    din_n;
  logic          rdy_n, busy_n;

  logic          edge_up, rd_ok, done, fill;
  logic          req_vld;
  logic [24:0]   req_addr;
  logic [AW-1:0] req_w, nxt_w;
  logic          hit0, hit1, hs, nhit;
  logic [15:0]   hit_word;

  assign mem_req = req_tgl;
  assign edge_up = ioctl_upload ^ upload_q;
  assign rd_ok   = ioctl_rd & ioctl_upload;
  assign done    = (mem_ack == req_tgl);
  assign fill    = (state == ST_FETCH || state == ST_PREFETCH) && done && !drop && !edge_up;

  // Slot view for this cycle: an upload edge clears it, a finished fetch lands in it.
  always_comb begin
    eff_vld = edge_up ? 2'b00 : slot_vld;
    eff_adr = slot_adr;
    eff_dat = slot_dat;
    if (fill) begin
      eff_vld[fetch_slot] = 1'b1;
      eff_adr[fetch_slot] = mem_a;
      eff_dat[fetch_slot] = mem_q;
    end
  end

  always_comb begin
    req_vld  = 1'b0;
    req_addr = ioctl_addr;
    case (state)
      ST_IDLE: begin
        if (rd_ok) req_vld = 1'b1;
        else if (pend_vld && !edge_up) begin
          req_vld  = 1'b1;
          req_addr = pend_addr;
        end
      end
      ST_FETCH, ST_PREFETCH: begin
        if (done) begin
          if (rd_ok) req_vld = 1'b1;
          else if (pend_vld && !edge_up) begin
            req_vld  = 1'b1;
            req_addr = pend_addr;
          end else if (state == ST_FETCH && !drop && !edge_up) begin
            req_vld  = 1'b1;
            req_addr = dem_addr;
          end
        end
      end
      default: ;
    endcase
  end

  assign req_w    = word_of(req_addr);
  assign nxt_w    = req_w + AW'(1);
  assign hit0     = eff_vld[0] && (eff_adr[0] == req_w);
  assign hit1     = eff_vld[1] && (eff_adr[1] == req_w);
  assign nhit     = (eff_vld[0] && (eff_adr[0] == nxt_w)) || (eff_vld[1] && (eff_adr[1] == nxt_w));
  assign hs       = hit1;
  assign hit_word = eff_dat[hs];

  always_comb begin
    state_n      = state;
    slot_vld_n   = eff_vld;
    slot_adr_n   = eff_adr;
    slot_dat_n   = eff_dat;
    mru_n        = mru;
    fetch_slot_n = fetch_slot;
    drop_n       = drop;
    pend_vld_n   = pend_vld && !edge_up;
    pend_addr_n  = pend_addr;
    dem_addr_n   = dem_addr;
    req_n        = req_tgl;
    mem_a_n      = mem_a;
    din_n        = ioctl_din;
    rdy_n        = ioctl_din_ready;
    case (state)
      ST_DRAIN: begin
        if (rd_ok) begin
          pend_vld_n  = 1'b1;
          pend_addr_n = ioctl_addr;
          rdy_n       = 1'b0;
        end
        if (done) begin
          state_n = ST_IDLE;
          drop_n  = 1'b0;
        end
      end
      ST_FETCH, ST_PREFETCH: begin
        if (!done) begin
          if (rd_ok) begin
            pend_vld_n  = 1'b1;
            pend_addr_n = ioctl_addr;
            rdy_n       = 1'b0;
          end
          if (edge_up) drop_n = 1'b1;
        end else begin
          state_n    = ST_IDLE;
          drop_n     = 1'b0;
          pend_vld_n = 1'b0;
        end
      end
      default: ;
    endcase
    // A hit serves next cycle; a miss evicts the least recently used slot.
    if (req_vld) begin
      pend_vld_n = 1'b0;
      if (hit0 || hit1) begin
        din_n   = req_addr[0] ? hit_word[15:8] : hit_word[7:0];
        rdy_n   = 1'b1;
        mru_n   = hs;
        state_n = ST_IDLE;
        if (PREFETCH != 0 && req_addr[0] && !nhit) begin
          state_n      = ST_PREFETCH;
          req_n        = ~req_tgl;
          mem_a_n      = nxt_w;
          fetch_slot_n = ~hs;
        end
      end else begin
        rdy_n        = 1'b0;
        state_n      = ST_FETCH;
        req_n        = ~req_tgl;
        mem_a_n      = req_w;
        fetch_slot_n = ~mru;
        mru_n        = ~mru;
        dem_addr_n   = req_addr;
      end
    end
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    upload_q   <= ioctl_upload;
    slot_adr   <= slot_adr_n;
    slot_dat   <= slot_dat_n;
    pend_addr  <= pend_addr_n;
    dem_addr   <= dem_addr_n;
    fetch_slot <= fetch_slot_n;
    if (reset) begin
      state           <= ST_DRAIN;
      slot_vld        <= 2'b00;
      pend_vld        <= 1'b0;
      drop            <= 1'b0;
      mru             <= 1'b0;
      mem_a           <= '0;
      ioctl_din       <= 8'd0;
      ioctl_din_ready <= 1'b0;
      busy            <= 1'b1;
    end else begin
      state           <= state_n;
      slot_vld        <= slot_vld_n;
      pend_vld        <= pend_vld_n;
      drop            <= drop_n;
      mru             <= mru_n;
      req_tgl         <= req_n;
      mem_a           <= mem_a_n;
      ioctl_din       <= din_n;
      ioctl_din_ready <= rdy_n;
      busy            <= busy_n;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: SDRAM toggle-handshake model, scoreboard of
// expected bytes, a vector table of sequential reads and hand-written corner cases.
module tb_ioctl_upload_reader;
  localparam int AW = 23;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset, ioctl_upload, ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_din_ready, busy, mem_req;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_q = 16'd0;

  logic          rd_b;
  logic [24:0]   addr_b;
  logic [7:0]    din_b;
  logic          ready_b, busy_b, req_b;
  logic          ack_b = 1'b0;
  logic [AW-1:0] a_b;
  logic [15:0]   q_b = 16'd0;

  ioctl_upload_reader #(.AW(AW), .BASE_WORD(0), .PREFETCH(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_din_ready(ioctl_din_ready),
    .busy(busy), .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_q(mem_q));

  ioctl_upload_reader #(.AW(AW), .BASE_WORD(32'h100000), .PREFETCH(1)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(rd_b),
    .ioctl_addr(addr_b), .ioctl_din(din_b), .ioctl_din_ready(ready_b),
    .busy(busy_b), .mem_req(req_b), .mem_ack(ack_b), .mem_a(a_b), .mem_q(q_b));

  int compared = 0;
  int mismatched = 0;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] w);
    if (w == '0) return 16'hBEEF;
    return {w[7:0] ^ 8'h5A, w[7:0] + 8'h31};
  endfunction

  // SDRAM model: acknowledges lat cycles after a toggle, counts toggles.
  int   cyc = 0;
  int   lat = 5;
  int   cnt = 0;
  int   nreq = 0;
  int   ack_cyc = 0;
  logic req_seen = 1'b0;
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (mem_req != req_seen) nreq <= nreq + 1;
    req_seen <= mem_req;
    if (mem_req != mem_ack) begin
      if (cnt + 1 >= lat) begin
        mem_ack <= mem_req;
        mem_q   <= mem_word(mem_a);
        cnt     <= 0;
        ack_cyc <= cyc + 1;
      end else cnt <= cnt + 1;
    end
  end

  int cnt_b = 0;
  always @(posedge clk_sys) begin
    if (req_b != ack_b) begin
      if (cnt_b >= 2) begin
        ack_b <= req_b;
        q_b   <= mem_word(a_b);
        cnt_b <= 0;
      end else cnt_b <= cnt_b + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  // Issues one read, then waits for and scores the byte; lat1 reports 1-cycle service.
  task automatic do_rd(input logic [24:0] a, output logic lat1);
    logic [15:0] w;
    logic [7:0]  e;
    int          waited;
    w = mem_word(AW'(a[24:1]));
    exp_q.push_back(a[0] ? w[15:8] : w[7:0]);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    lat1     = ioctl_din_ready;
    waited   = 0;
    while (!ioctl_din_ready && waited < 40) begin
      @(negedge clk_sys);
      waited++;
    end
    e = exp_q.pop_front();
    if (!ioctl_din_ready) check($sformatf("rd_ready_timeout@%0h", a), ioctl_din_ready, 1);
    else begin
      if (!lat1) check($sformatf("fetch_latency@%0h", a), cyc, ack_cyc + 1);
      check($sformatf("rd_byte@%0h", a), ioctl_din, e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    if (busy) check("busy_timeout", busy, 0);
    @(negedge clk_sys);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic        lat1;
    int          reqs;
  } vec_t;
  vec_t vecs[11];

  logic        l1;
  int          n0, n;
  logic        req_saved;
  logic [15:0] wb;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{25'd3,  1'b1, 1};
    vecs[1]  = '{25'd4,  1'b1, 0};
    vecs[2]  = '{25'd5,  1'b1, 1};
    vecs[3]  = '{25'd0,  1'b0, 1};
    vecs[4]  = '{25'd9,  1'b0, 2};
    vecs[5]  = '{25'd8,  1'b1, 0};
    vecs[6]  = '{25'd11, 1'b1, 1};
    vecs[7]  = '{25'd10, 1'b1, 0};
    vecs[8]  = '{25'd12, 1'b1, 0};
    vecs[9]  = '{25'd7,  1'b0, 2};
    vecs[10] = '{25'd7,  1'b1, 0};

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    rd_b = 1'b0; addr_b = '0;
    repeat (3) @(negedge clk_sys);
    check("reset_busy", busy, 1);
    check("reset_din", ioctl_din, 0);
    check("reset_ready", ioctl_din_ready, 0);
    check("reset_mem_a", mem_a, 0);
    check("reset_mem_req", mem_req, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    check("drain_1cycle_busy", busy, 0);
    check("drain_no_toggle", mem_req, 0);
    check("drain_ready", ioctl_din_ready, 0);

    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // Demand fetch, 1-cycle hit on the odd byte, prefetch, pending read served by prefetch.
    n0 = nreq;
    do_rd(25'h0, l1);
    check("first_rd_lat1", l1, 0);
    check("first_rd_mem_a", mem_a, 0);
    check("first_rd_reqs", nreq - n0, 1);
    do_rd(25'h1, l1);
    check("odd_rd_lat1", l1, 1);
    check("prefetch_mem_a", mem_a, 1);
    check("prefetch_outstanding", mem_req != mem_ack, 1);
    do_rd(25'h2, l1);
    check("pending_rd_lat1", l1, 0);
    wait_idle();
    check("prefetch_seq_reqs", nreq - n0, 2);

    // BASE_WORD offset truncated to AW bits.
    addr_b = 25'h1FFFFFE;
    rd_b   = 1'b1;
    @(negedge clk_sys);
    rd_b = 1'b0;
    check("base_wrap_mem_a", a_b, 23'h0FFFFF);
    check("base_req_out", req_b != ack_b, 1);
    n = 0;
    while (!ready_b && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    wb = mem_word(23'h0FFFFF);
    check("base_ready", ready_b, 1);
    check("base_byte", din_b, wb[7:0]);

    for (int i = 0; i < 11; i++) begin
      n0 = nreq;
      do_rd(vecs[i].addr, l1);
      check($sformatf("vec%0d_lat1", i), l1, vecs[i].lat1);
      wait_idle();
      check($sformatf("vec%0d_reqs", i), nreq - n0, vecs[i].reqs);
    end

    // Reset two cycles after a toggle; the late ack must be drained and discarded.
    lat = 8;
    ioctl_addr = 25'h40;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd  = 1'b0;
    req_saved = mem_req;
    check("rst_req_issued", mem_req != mem_ack, 1);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    n = 0;
    while (mem_ack != mem_req && n < 20) begin
      check("drain_busy", busy, 1);
      check("drain_req_held", mem_req, req_saved);
      check("drain_ready", ioctl_din_ready, 0);
      @(negedge clk_sys);
      n++;
    end
    check("drain_ack_seen", mem_ack == mem_req, 1);
    check("drain_busy_at_ack", busy, 1);
    @(negedge clk_sys);
    check("drain_done_busy", busy, 0);
    check("drain_done_ready", ioctl_din_ready, 0);
    check("drain_done_din", ioctl_din, 0);
    check("drain_req_final", mem_req, req_saved);
    lat = 5;
    n0 = nreq;
    do_rd(25'h40, l1);
    check("post_rst_miss", l1, 0);
    wait_idle();
    check("post_rst_reqs", nreq - n0, 1);

    // Upload edges flush the cache; reads with upload low are ignored.
    do_rd(25'h0, l1);
    wait_idle();
    n0 = nreq;
    do_rd(25'h0, l1);
    check("cached_hit", l1, 1);
    wait_idle();
    check("cached_reqs", nreq - n0, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n0 = nreq;
    ioctl_addr = 25'h0;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("ignored_rd_reqs", nreq - n0, 0);
    check("ignored_rd_busy", busy, 0);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    n0 = nreq;
    do_rd(25'h0, l1);
    check("reupload_miss", l1, 0);
    wait_idle();
    check("reupload_reqs", nreq - n0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
